// File: rtl/fb_dac_if.sv
// Correction-word bundle from the feedback calc stage to the kicker DAC driver.
// The calc stage is the master; the DAC driver consumes it through the slave modport.
interface fb_dac_if;
    logic        fb_en;
    logic        fb_cond;
    logic [14:0] pout;
    logic        dsp_oflow;

    modport master (output fb_en, fb_cond, pout, dsp_oflow);
    modport slave  (input  fb_en, fb_cond, pout, dsp_oflow);
endinterface

// File: rtl/fb_dac_driver.sv
// Kicker DAC driver: captures the signed correction word on the fb_cond rising
// edge, clamps it to the DAC range, converts to offset binary and presents it
// on a parallel bus with a write pulse. Falls back to midscale when feedback is
// disabled or no update arrives for TIMEOUT idle cycles. Keeps sticky status.
module fb_dac_driver #(
    parameter int DAC_BITS  = 14,
    parameter int WR_CYCLES = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    fb_dac_if.slave             fb,
    input  logic                clr_stat,
    output logic [DAC_BITS-1:0] dac_data,
    output logic                dac_wr,
    output logic                busy,
    output logic                sat_flag,
    output logic [7:0]          oflow_cnt,
    output logic                miss_flag,
    output logic                timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_CONVERT = 3'd2,
        S_LOAD    = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    localparam logic [DAC_BITS-1:0] MIDSCALE  = {1'b1, {(DAC_BITS-1){1'b0}}};
    localparam logic [2:0]          WR_LAST   = 3'(WR_CYCLES);
    localparam logic [15:0]         TMO_LAST  = 16'(TIMEOUT);
    localparam logic [7:0]          OFLOW_MAX = 8'hFF;

    // Clamp a (DAC_BITS+1)-bit signed word into DAC_BITS signed range.
    // Result is {clamped_flag, clamped_word}; a clamp is needed exactly when
    // the two top bits disagree (value not representable in DAC_BITS).
    function automatic logic [DAC_BITS:0] clamp_word(input logic [DAC_BITS:0] w);
        logic [DAC_BITS:0] r;
        if (w[DAC_BITS] == 1'b0 && w[DAC_BITS-1] == 1'b1) begin
            r = {1'b1, 1'b0, {(DAC_BITS-1){1'b1}}};
        end else if (w[DAC_BITS] == 1'b1 && w[DAC_BITS-1] == 1'b0) begin
            r = {1'b1, 1'b1, {(DAC_BITS-1){1'b0}}};
        end else begin
            r = {1'b0, w[DAC_BITS-1:0]};
        end
        return r;
    endfunction

    // Two's complement to offset binary: flip the sign bit.
    function automatic logic [DAC_BITS-1:0] to_offset(input logic [DAC_BITS-1:0] c);
        return {~c[DAC_BITS-1], c[DAC_BITS-2:0]};
    endfunction

    state_t                state_q, state_d;
    logic                  fb_cond_q;
    logic                  fb_en_q;
    logic [DAC_BITS:0]     pout_q, pout_d;
    logic                  oflow_q, oflow_d;
    logic [DAC_BITS-1:0]   clamp_q, clamp_d;
    logic [DAC_BITS-1:0]   code_q, code_d;
    logic [DAC_BITS-1:0]   dac_data_q, dac_data_d;
    logic                  dac_wr_q, dac_wr_d;
    logic                  busy_q, busy_d;
    logic [2:0]            wr_cnt_q, wr_cnt_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  mid_req_q, mid_req_d;
    logic                  mid_seq_q, mid_seq_d;   // current sequence is a midscale write
    logic                  tmo_src_q, tmo_src_d;   // midscale write was caused by timeout
    logic                  sat_q, sat_d;
    logic                  miss_q, miss_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic [7:0]            oflow_cnt_q, oflow_cnt_d;

    logic                  rise_s;
    logic                  fall_s;
    logic                  tmo_hit_s;
    logic                  miss_ev_s;
    logic [DAC_BITS:0]     clamp_s;

    assign rise_s    = fb.fb_cond & ~fb_cond_q;
    assign fall_s    = fb_en_q & ~fb.fb_en;
    assign tmo_hit_s = fb.fb_en & (state_q == S_IDLE) & (tmo_cnt_q == TMO_LAST);
    assign miss_ev_s = rise_s & fb.fb_en & (state_q != S_IDLE);
    assign clamp_s   = clamp_word(pout_q);

    // Next-state, datapath and status update logic for the capture/write sequence.
    always_comb begin
        state_d     = state_q;
        pout_d      = pout_q;
        oflow_d     = oflow_q;
        clamp_d     = clamp_q;
        code_d      = code_q;
        dac_data_d  = dac_data_q;
        dac_wr_d    = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        mid_req_d   = mid_req_q | fall_s;
        mid_seq_d   = mid_seq_q;
        tmo_src_d   = tmo_src_q;
        sat_d       = sat_q & ~clr_stat;
        miss_d      = (miss_q & ~clr_stat) | miss_ev_s;
        tmo_flag_d  = tmo_flag_q & ~clr_stat;
        oflow_cnt_d = clr_stat ? 8'h00 : oflow_cnt_q;

        if (!fb.fb_en) begin
            tmo_cnt_d = 16'h0000;
        end else if (state_q == S_IDLE && tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + 16'h0001;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rise_s && fb.fb_en) begin
                    pout_d    = fb.pout;
                    oflow_d   = fb.dsp_oflow;
                    mid_seq_d = 1'b0;
                    tmo_src_d = 1'b0;
                    state_d   = S_CAPTURE;
                end else if (mid_req_q || fall_s || tmo_hit_s) begin
                    code_d    = MIDSCALE;
                    mid_seq_d = 1'b1;
                    tmo_src_d = tmo_hit_s;
                    mid_req_d = 1'b0;
                    state_d   = S_LOAD;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (!fb.fb_en) begin
                    state_d = S_IDLE;
                end else begin
                    clamp_d = clamp_s[DAC_BITS-1:0];
                    sat_d   = sat_d | clamp_s[DAC_BITS];
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (!fb.fb_en) begin
                    state_d = S_IDLE;
                end else if (oflow_q) begin
                    // overflowed words never reach the DAC, only the counter
                    if (clr_stat) begin
                        oflow_cnt_d = 8'h01;
                    end else if (oflow_cnt_q == OFLOW_MAX) begin
                        oflow_cnt_d = OFLOW_MAX;
                    end else begin
                        oflow_cnt_d = oflow_cnt_q + 8'h01;
                    end
                    state_d = S_IDLE;
                end else begin
                    code_d    = to_offset(clamp_q);
                    tmo_src_d = 1'b0;
                    mid_req_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!fb.fb_en && !mid_seq_q) begin
                    state_d = S_IDLE;
                end else begin
                    dac_data_d = code_q;
                    wr_cnt_d   = 3'd0;
                    tmo_cnt_d  = 16'h0000;
                    tmo_flag_d = tmo_flag_d | tmo_src_q;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                // first WRITE cycle is data setup; the pulse, once started, always completes
                if (wr_cnt_q == 3'd0 && !fb.fb_en && !mid_seq_q) begin
                    state_d = S_IDLE;
                end else if (wr_cnt_q == WR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    dac_wr_d = 1'b1;
                    wr_cnt_d = wr_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // All state, datapath and status registers; reset parks the DAC at midscale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fb_cond_q   <= 1'b0;
            fb_en_q     <= 1'b0;
            pout_q      <= '0;
            oflow_q     <= 1'b0;
            clamp_q     <= '0;
            code_q      <= MIDSCALE;
            dac_data_q  <= MIDSCALE;
            dac_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_cnt_q    <= 3'd0;
            tmo_cnt_q   <= 16'h0000;
            mid_req_q   <= 1'b0;
            mid_seq_q   <= 1'b0;
            tmo_src_q   <= 1'b0;
            sat_q       <= 1'b0;
            miss_q      <= 1'b0;
            tmo_flag_q  <= 1'b0;
            oflow_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            fb_cond_q   <= fb.fb_cond;
            fb_en_q     <= fb.fb_en;
            pout_q      <= pout_d;
            oflow_q     <= oflow_d;
            clamp_q     <= clamp_d;
            code_q      <= code_d;
            dac_data_q  <= dac_data_d;
            dac_wr_q    <= dac_wr_d;
            busy_q      <= busy_d;
            wr_cnt_q    <= wr_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mid_req_q   <= mid_req_d;
            mid_seq_q   <= mid_seq_d;
            tmo_src_q   <= tmo_src_d;
            sat_q       <= sat_d;
            miss_q      <= miss_d;
            tmo_flag_q  <= tmo_flag_d;
            oflow_cnt_q <= oflow_cnt_d;
        end
    end

    assign dac_data     = dac_data_q;
    assign dac_wr       = dac_wr_q;
    assign busy         = busy_q;
    assign sat_flag     = sat_q;
    assign oflow_cnt    = oflow_cnt_q;
    assign miss_flag    = miss_q;
    assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_fb_dac_driver.sv
// Bench for fb_dac_driver: directed words with hand-computed DAC codes pushed
// into a scoreboard queue; a monitor pops one entry per dac_wr pulse and checks
// data, pulse width and data stability. Status and timing are checked inline.
module tb_fb_dac_driver;
    localparam int WR  = 2;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_stat;
    logic [13:0] dac_data;
    logic        dac_wr;
    logic        busy;
    logic        sat_flag;
    logic [7:0]  oflow_cnt;
    logic        miss_flag;
    logic        timeout_flag;

    fb_dac_if fb ();

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];

    logic [14:0] norm_word [3] = '{15'h0007, 15'h7F00, 15'h1000};
    logic [13:0] norm_code [3] = '{14'h2007, 14'h1F00, 14'h3000};

    always #5 clk = ~clk;

    fb_dac_driver #(.DAC_BITS(14), .WR_CYCLES(WR), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fb           (fb),
        .clr_stat     (clr_stat),
        .dac_data     (dac_data),
        .dac_wr       (dac_wr),
        .busy         (busy),
        .sat_flag     (sat_flag),
        .oflow_cnt    (oflow_cnt),
        .miss_flag    (miss_flag),
        .timeout_flag (timeout_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // fb_cond high for one cycle with the word, then low until the next rise slot
    task automatic drive_word(input logic [14:0] p, input logic of, input int gap);
        fb.pout      = p;
        fb.dsp_oflow = of;
        fb.fb_cond   = 1'b1;
        tick();
        fb.fb_cond   = 1'b0;
        fb.dsp_oflow = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic pulse_clr();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
    endtask

    // Scoreboard monitor: one expected word per dac_wr pulse
    initial begin : monitor
        logic        wr_prev;
        int          width;
        logic [13:0] held;
        wr_prev = 1'b0;
        width   = 0;
        held    = 14'h0000;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                wr_prev = 1'b0;
                width   = 0;
            end else begin
                if (dac_wr && !wr_prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_wr: got write of 0x%0h expected no write", dac_data);
                    end else begin
                        chk("wr_data", dac_data, exp_q.pop_front());
                    end
                    width = 1;
                    held  = dac_data;
                end else if (dac_wr) begin
                    width++;
                    chk("wr_hold", dac_data, held);
                end else if (wr_prev) begin
                    chk("wr_width", width, WR);
                end
                wr_prev = dac_wr;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n        = 1'b0;
        clr_stat     = 1'b0;
        fb.fb_en     = 1'b0;
        fb.fb_cond   = 1'b0;
        fb.pout      = 15'h0000;
        fb.dsp_oflow = 1'b0;
        repeat (3) tick();
        at_neg();
        chk("rst_data", dac_data, 14'h2000);
        chk("rst_wr", dac_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_oflow", oflow_cnt, 8'h00);
        chk("rst_flags", {sat_flag, miss_flag, timeout_flag}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        fb.fb_en = 1'b1;
        repeat (2) tick();

        // nominal +100 with cycle-exact timing
        exp_q.push_back(14'h2064);
        drive_word(15'h0064, 1'b0, 1);
        at_neg(); chk("nom_busy_n1", busy, 1'b1);
        repeat (3) tick();
        at_neg(); chk("nom_data_n4", dac_data, 14'h2064); chk("nom_wr_n4", dac_wr, 1'b0);
        tick(); at_neg(); chk("nom_wr_n5", dac_wr, 1'b1);
        tick(); at_neg(); chk("nom_wr_n6", dac_wr, 1'b1);
        tick(); at_neg(); chk("nom_wr_n7", dac_wr, 1'b0); chk("nom_busy_n7", busy, 1'b0);
        chk("nom_sat", sat_flag, 1'b0);
        repeat (3) tick();

        // clamp and sign
        exp_q.push_back(14'h3FFF);
        drive_word(15'h2EE0, 1'b0, 8);
        at_neg(); chk("pos_clamp_data", dac_data, 14'h3FFF); chk("pos_clamp_sat", sat_flag, 1'b1);
        exp_q.push_back(14'h0000);
        drive_word(15'h4000, 1'b0, 8);
        at_neg(); chk("neg_clamp_data", dac_data, 14'h0000); chk("neg_clamp_sat", sat_flag, 1'b1);
        pulse_clr();
        at_neg(); chk("sat_clr", sat_flag, 1'b0);
        exp_q.push_back(14'h1FFF);
        drive_word(15'h7FFF, 1'b0, 8);
        at_neg(); chk("minus1_data", dac_data, 14'h1FFF);
        exp_q.push_back(14'h3FFF);
        drive_word(15'h1FFF, 1'b0, 8);
        at_neg(); chk("max_data", dac_data, 14'h3FFF);
        exp_q.push_back(14'h0000);
        drive_word(15'h6000, 1'b0, 8);
        at_neg(); chk("min_data", dac_data, 14'h0000); chk("edge_nosat", sat_flag, 1'b0);

        // single overflow capture: no write, counter +1
        drive_word(15'h01F4, 1'b1, 8);
        at_neg(); chk("oflow_one", oflow_cnt, 8'h01); chk("oflow_hold", dac_data, 14'h0000);

        // 299 more overflow captures with a normal write every 100
        for (int i = 0; i < 299; i++) begin
            if (i % 100 == 0) begin
                exp_q.push_back(norm_code[i / 100]);
                drive_word(norm_word[i / 100], 1'b0, 8);
            end
            drive_word(15'h01F4, 1'b1, 4);
        end
        repeat (4) tick();
        at_neg(); chk("oflow_sat", oflow_cnt, 8'hFF); chk("oflow_last_data", dac_data, 14'h3000);

        // clr_stat in the same cycle as an increment: counter reads 1
        drive_word(15'h01F4, 1'b1, 2);
        pulse_clr();
        repeat (4) tick();
        at_neg(); chk("clr_vs_inc", oflow_cnt, 8'h01);

        // second rise 4 cycles after the first is missed
        exp_q.push_back(14'h2200);
        drive_word(15'h0200, 1'b0, 4);
        drive_word(15'h0201, 1'b0, 8);
        at_neg(); chk("miss_set", miss_flag, 1'b1); chk("miss_data", dac_data, 14'h2200);
        pulse_clr();
        at_neg(); chk("miss_clr", miss_flag, 1'b0);

        // fb_en dropped while dac_wr is high: pulse completes, then midscale
        exp_q.push_back(14'h2300);
        exp_q.push_back(14'h2000);
        drive_word(15'h0300, 1'b0, 1);
        repeat (4) tick();
        fb.fb_en = 1'b0;
        repeat (12) tick();
        at_neg(); chk("dis_mid_data", dac_data, 14'h2000); chk("dis_busy", busy, 1'b0);
        chk("dis_tmo_flag", timeout_flag, 1'b0);
        drive_word(15'h0123, 1'b0, 8);
        at_neg(); chk("dis_nomiss", miss_flag, 1'b0); chk("dis_nocap", dac_data, 14'h2000);

        // timeout midscale write after TMO idle cycles
        fb.fb_en = 1'b1;
        repeat (2) tick();
        exp_q.push_back(14'h2400);
        exp_q.push_back(14'h2000);
        drive_word(15'h0400, 1'b0, 1);
        repeat (262) tick();
        at_neg(); chk("tmo_pre_flag", timeout_flag, 1'b0); chk("tmo_pre_data", dac_data, 14'h2400);
        tick();
        at_neg(); chk("tmo_flag", timeout_flag, 1'b1); chk("tmo_data", dac_data, 14'h2000);
        repeat (4) tick();

        // asynchronous reset in the middle of a write pulse
        exp_q.push_back(14'h2500);
        drive_word(15'h0500, 1'b0, 1);
        repeat (5) tick();
        chk("pre_rst_wr", dac_wr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr", dac_wr, 1'b0);
        chk("arst_data", dac_data, 14'h2000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_oflow", oflow_cnt, 8'h00);
        chk("arst_flags", {sat_flag, miss_flag, timeout_flag}, 3'b000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        at_neg();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
